// File: rtl/q100_wb_pkg.sv
// Shared types for the q100 write-back stage: FSM states and load funct3 codes.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package q100_wb_pkg;

    typedef enum logic {
        WB_RUN       = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/q100_config.svh
// q100 shared configuration: field widths and opcodes used across the pipeline.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef Q100_CONFIG_SVH
`define Q100_CONFIG_SVH

`define LEN_OPCODE  7
`define LEN_FUNCT3  3
`define LEN_RD      5
`define LEN_REG     32
`define LEN_REG_VAL 32

`define OPCODE_LB_LH_LW_LBU_LHU 7'b0000011
`define OPCODE_JAL              7'b1101111
`define OPCODE_JALR             7'b1100111

`endif

// File: rtl/q100_load_align.sv
// Load data aligner: picks byte/half/word from an aligned memory word and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: word (raw aligned word), funct3 (load width/sign), off (byte offset), result.
module q100_load_align
    import q100_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Half-word loads only look at off[1]; a misaligned half is not split.
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (funct3)
            F3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
            // LW and the undefined codes take the whole word.
            default: result = word;
        endcase
    end

endmodule

// File: rtl/q100_writeback.sv
// q100 write-back stage: selects the result, owns the 32-entry register file, bypasses to decode.
// Latency: commit is combinational on the bypass port; xn_o shows the value one cycle later.
// Backpressure: stall_o holds the upstream pipeline while a load waits on mem_valid_i.
// Ports: clk/rst (sync, active-high); MEM-stage inputs (valid_i, WB_i, M_i, opcode_i, funct3_i,
// rd_i, pc_i, alu_result_i); data memory return (mem_rdata_i, mem_valid_i); stall_o; xn_o;
// bypass (rd_WB_o, xn_result_WB_o, reg_wr_WB_o); instret_o only with Q100_WB_INSTRET_EN defined.
`include "q100_config.svh"

module q100_writeback
    import q100_wb_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int XLEN    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic                           WB_i,
    input  logic                           M_i,
    input  logic [`LEN_OPCODE-1:0]         opcode_i,
    input  logic [`LEN_FUNCT3-1:0]         funct3_i,
    input  logic [`LEN_RD-1:0]             rd_i,
    input  logic [XLEN-1:0]                pc_i,
    input  logic [XLEN-1:0]                alu_result_i,
    input  logic [XLEN-1:0]                mem_rdata_i,
    input  logic                           mem_valid_i,
    output logic                           stall_o,
    output logic [REG_NUM-1:0][XLEN-1:0]   xn_o,
    output logic [`LEN_RD-1:0]             rd_WB_o,
    output logic [XLEN-1:0]                xn_result_WB_o,
    output logic                           reg_wr_WB_o
`ifdef Q100_WB_INSTRET_EN
    ,
    output logic [63:0]                    instret_o
`endif
);

    wb_state_t               state_q;
    wb_state_t               state_d;
    logic [`LEN_RD-1:0]      hold_rd_q;
    logic [`LEN_FUNCT3-1:0]  hold_f3_q;
    logic [1:0]              hold_off_q;
    logic                    capture;

    logic                    is_load;
    logic                    commit;
    logic [`LEN_RD-1:0]      commit_rd;
    logic [XLEN-1:0]         commit_val;
    logic                    wr_en;

    logic [`LEN_FUNCT3-1:0]  align_f3;
    logic [1:0]              align_off;
    logic [XLEN-1:0]         load_val;

    logic [XLEN-1:0]         regs [REG_NUM];

    assign is_load = valid_i && WB_i && M_i && (opcode_i == `OPCODE_LB_LH_LW_LBU_LHU);

    // While waiting, the live MEM inputs may already belong to the next instruction,
    // so the aligner must use the captured funct3/offset instead.
    assign align_f3  = (state_q == WB_LOAD_WAIT) ? hold_f3_q  : funct3_i;
    assign align_off = (state_q == WB_LOAD_WAIT) ? hold_off_q : alu_result_i[1:0];

    q100_load_align #(
        .XLEN   (XLEN)
    ) u_load_align (
        .word   (mem_rdata_i),
        .funct3 (align_f3),
        .off    (align_off),
        .result (load_val)
    );

    always_comb begin
        state_d    = state_q;
        stall_o    = 1'b0;
        commit     = 1'b0;
        commit_rd  = '0;
        commit_val = '0;
        capture    = 1'b0;
        case (state_q)
            WB_RUN: begin
                if (is_load) begin
                    if (mem_valid_i) begin
                        commit     = 1'b1;
                        commit_rd  = rd_i;
                        commit_val = load_val;
                    end else begin
                        capture = 1'b1;
                        stall_o = 1'b1;
                        state_d = WB_LOAD_WAIT;
                    end
                end else if (valid_i && WB_i) begin
                    commit    = 1'b1;
                    commit_rd = rd_i;
                    if (opcode_i == `OPCODE_JAL || opcode_i == `OPCODE_JALR) begin
                        // Link address wraps naturally at XLEN bits.
                        commit_val = pc_i + XLEN'(4);
                    end else begin
                        commit_val = alu_result_i;
                    end
                end
            end
            WB_LOAD_WAIT: begin
                if (mem_valid_i) begin
                    commit     = 1'b1;
                    commit_rd  = hold_rd_q;
                    commit_val = load_val;
                    state_d    = WB_RUN;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = WB_RUN;
        endcase
        // Reset forces all handshake outputs quiet regardless of inputs.
        if (rst) begin
            stall_o = 1'b0;
            commit  = 1'b0;
        end
    end

    // x0 is never written; a commit to rd=0 still retires but produces no write.
    assign wr_en          = commit && (commit_rd != '0);
    assign reg_wr_WB_o    = wr_en;
    assign rd_WB_o        = wr_en ? commit_rd  : '0;
    assign xn_result_WB_o = wr_en ? commit_val : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WB_RUN;
            hold_rd_q  <= '0;
            hold_f3_q  <= '0;
            hold_off_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_rd_q  <= rd_i;
                hold_f3_q  <= funct3_i;
                hold_off_q <= alu_result_i[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[commit_rd] <= commit_val;
        end
    end

    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            xn_o[i] = (i == 0) ? '0 : regs[i];
        end
    end

`ifdef Q100_WB_INSTRET_EN
    logic        retire;
    logic [63:0] instret_q;

    // Retire: any real non-load instruction in RUN, or a load on its data return.
    assign retire = ((state_q == WB_RUN) && valid_i && !(is_load && !mem_valid_i)) ||
                    ((state_q == WB_LOAD_WAIT) && mem_valid_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_q100_writeback.sv
// Self-checking bench for q100_writeback: scoreboard of expected bypass writes plus register checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_q100_writeback;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic              WB_i;
    logic              M_i;
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rd_i;
    logic [31:0]       pc_i;
    logic [31:0]       alu_result_i;
    logic [31:0]       mem_rdata_i;
    logic              mem_valid_i;
    logic              stall_o;
    logic [31:0][31:0] xn_o;
    logic [4:0]        rd_WB_o;
    logic [31:0]       xn_result_WB_o;
    logic              reg_wr_WB_o;
`ifdef Q100_WB_INSTRET_EN
    logic [63:0]       instret_o;
`endif

    int      checks = 0;
    int      errors = 0;
    wb_exp_t exp_q[$];
    longint  exp_ret = 0;

    q100_writeback #(
        .REG_NUM (32),
        .XLEN    (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .WB_i           (WB_i),
        .M_i            (M_i),
        .opcode_i       (opcode_i),
        .funct3_i       (funct3_i),
        .rd_i           (rd_i),
        .pc_i           (pc_i),
        .alu_result_i   (alu_result_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_valid_i    (mem_valid_i),
        .stall_o        (stall_o),
        .xn_o           (xn_o),
        .rd_WB_o        (rd_WB_o),
        .xn_result_WB_o (xn_result_WB_o),
        .reg_wr_WB_o    (reg_wr_WB_o)
`ifdef Q100_WB_INSTRET_EN
        ,
        .instret_o      (instret_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit wb, input bit m, input logic [6:0] op,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rdata, input bit mv);
        valid_i      = v;
        WB_i         = wb;
        M_i          = m;
        opcode_i     = op;
        funct3_i     = f3;
        rd_i         = rd;
        pc_i         = pc;
        alu_result_i = alu;
        mem_rdata_i  = rdata;
        mem_valid_i  = mv;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] val);
        wb_exp_t e;
        e.rd  = rd;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic chk_instret(input string tag);
`ifdef Q100_WB_INSTRET_EN
        chk(tag, instret_o, exp_ret);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // Scoreboard: every bypass write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reg_wr_WB_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", {59'd0, rd_WB_o}, 64'd0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {59'd0, rd_WB_o}, {59'd0, e.rd});
                chk("wb_val", {32'd0, xn_result_WB_o}, {32'd0, e.val});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cycles;
        rst = 1'b1;
        drive(1, 1, 0, OP_ADDI, 3'd0, 5'd4, 32'h0, 32'hAAAA, 32'h0, 1);
        step();
        step();
        // Outputs must be quiet during reset even with a live instruction on the inputs.
        chk("rst_stall", {63'd0, stall_o}, 64'd0);
        chk("rst_reg_wr", {63'd0, reg_wr_WB_o}, 64'd0);
        chk("rst_rd_wb", {59'd0, rd_WB_o}, 64'd0);
        chk("rst_res_wb", {32'd0, xn_result_WB_o}, 64'd0);
        chk("rst_xn_zero", {63'd0, |xn_o}, 64'd0);
        chk_instret("rst_instret");
        rst = 1'b0;
        drive(0, 0, 0, 7'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        step();

        // ADDI rd=5: bypass this cycle, register visible next cycle.
        expect_wr(5'd5, 32'h1234);
        drive(1, 1, 0, OP_ADDI, 3'd0, 5'd5, 32'h100, 32'h1234, 32'h0, 0);
        chk("addi_pre_xn5", {32'd0, xn_o[5]}, 64'd0);
        step(); exp_ret++;
        chk("addi_xn5", {32'd0, xn_o[5]}, 64'h1234);
        chk_instret("addi_instret");

        // rd=0: no write, still retires.
        drive(1, 1, 0, OP_ADDI, 3'd0, 5'd0, 32'h104, 32'hFFFF_FFFF, 32'h0, 0);
        chk("x0_reg_wr", {63'd0, reg_wr_WB_o}, 64'd0);
        step(); exp_ret++;
        chk("x0_xn0", {32'd0, xn_o[0]}, 64'd0);
        chk_instret("x0_instret");

        // Loads with memory ready: no stall, aligned/extended result.
        expect_wr(5'd10, 32'hFFFF_FF80);
        drive(1, 1, 1, OP_LOAD, 3'b000, 5'd10, 32'h0, 32'h1003, 32'h80FF_FFFF, 1);
        chk("lb_stall", {63'd0, stall_o}, 64'd0);
        step(); exp_ret++;
        chk("lb_xn10", {32'd0, xn_o[10]}, 64'hFFFF_FF80);
        expect_wr(5'd11, 32'h0000_0080);
        drive(1, 1, 1, OP_LOAD, 3'b100, 5'd11, 32'h0, 32'h1003, 32'h80FF_FFFF, 1);
        step(); exp_ret++;
        chk("lbu_xn11", {32'd0, xn_o[11]}, 64'h0000_0080);
        expect_wr(5'd12, 32'hFFFF_80FF);
        drive(1, 1, 1, OP_LOAD, 3'b001, 5'd12, 32'h0, 32'h1002, 32'h80FF_FFFF, 1);
        step(); exp_ret++;
        chk("lh_xn12", {32'd0, xn_o[12]}, 64'hFFFF_80FF);
        expect_wr(5'd13, 32'h0000_FFFF);
        drive(1, 1, 1, OP_LOAD, 3'b101, 5'd13, 32'h0, 32'h1000, 32'h80FF_FFFF, 1);
        step(); exp_ret++;
        chk("lhu_xn13", {32'd0, xn_o[13]}, 64'h0000_FFFF);
        expect_wr(5'd14, 32'h80FF_FFFF);
        drive(1, 1, 1, OP_LOAD, 3'b111, 5'd14, 32'h0, 32'h1003, 32'h80FF_FFFF, 1);
        step(); exp_ret++;
        chk("lundef_xn14", {32'd0, xn_o[14]}, 64'h80FF_FFFF);
        chk_instret("load_instret");

        // LW rd=7 with three cycles of memory latency; inputs change meanwhile.
        stall_cycles = 0;
        drive(1, 1, 1, OP_LOAD, 3'b010, 5'd7, 32'h0, 32'h2000, 32'h0, 0);
        if (stall_o) stall_cycles++;
        step();
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 1, OP_LOAD, 3'b000, 5'd9, 32'h0, 32'h3003, 32'h0, 0);
            if (stall_o) stall_cycles++;
            step();
        end
        expect_wr(5'd7, 32'hDEAD_BEEF);
        drive(1, 1, 1, OP_LOAD, 3'b000, 5'd9, 32'h0, 32'h3003, 32'hDEAD_BEEF, 1);
        chk("lw_release_stall", {63'd0, stall_o}, 64'd0);
        step(); exp_ret++;
        chk("lw_stall_cycles", 64'(stall_cycles), 64'd3);
        chk("lw_xn7", {32'd0, xn_o[7]}, 64'hDEAD_BEEF);
        chk("lw_xn9_untouched", {32'd0, xn_o[9]}, 64'd0);
        chk_instret("lw_instret");

        // Back in RUN: an ALU write commits immediately; stray mem_valid_i is ignored.
        expect_wr(5'd9, 32'h77);
        drive(1, 1, 0, OP_ADDI, 3'd0, 5'd9, 32'h0, 32'h77, 32'h5555_5555, 1);
        chk("run_stall", {63'd0, stall_o}, 64'd0);
        step(); exp_ret++;
        chk("run_xn9", {32'd0, xn_o[9]}, 64'h77);

        // Links: JAL wraps, JALR normal.
        expect_wr(5'd1, 32'h99);
        drive(1, 1, 0, OP_ADDI, 3'd0, 5'd1, 32'h0, 32'h99, 32'h0, 0);
        step(); exp_ret++;
        expect_wr(5'd1, 32'h0);
        drive(1, 1, 0, OP_JAL, 3'd0, 5'd1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 0);
        step(); exp_ret++;
        chk("jal_wrap_xn1", {32'd0, xn_o[1]}, 64'd0);
        expect_wr(5'd2, 32'h104);
        drive(1, 1, 0, OP_JALR, 3'd0, 5'd2, 32'h100, 32'hABCD, 32'h0, 0);
        step(); exp_ret++;
        chk("jalr_xn2", {32'd0, xn_o[2]}, 64'h104);

        // Store: retires without writing; bubble does neither.
        drive(1, 0, 1, OP_STORE, 3'b010, 5'd3, 32'h0, 32'h4000, 32'h0, 0);
        chk("store_reg_wr", {63'd0, reg_wr_WB_o}, 64'd0);
        chk("store_rd_wb", {59'd0, rd_WB_o}, 64'd0);
        step(); exp_ret++;
        drive(0, 1, 0, OP_ADDI, 3'd0, 5'd3, 32'h0, 32'h4000, 32'h0, 0);
        step();
        chk("store_xn3", {32'd0, xn_o[3]}, 64'd0);
        chk_instret("store_instret");

        // Reset while a load waits: pending load is dropped.
        drive(1, 1, 1, OP_LOAD, 3'b010, 5'd8, 32'h0, 32'h5000, 32'h0, 0);
        chk("ldwait_stall", {63'd0, stall_o}, 64'd0 + 64'd1);
        step();
        rst = 1'b1;
        drive(0, 0, 0, 7'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        chk("rst_wait_stall", {63'd0, stall_o}, 64'd0);
        step();
        rst = 1'b0;
        exp_ret = 0;
        drive(0, 0, 0, 7'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h1111_1111, 1);
        chk("post_rst_stall", {63'd0, stall_o}, 64'd0);
        step();
        chk("post_rst_xn_zero", {63'd0, |xn_o}, 64'd0);
        chk("post_rst_xn8", {32'd0, xn_o[8]}, 64'd0);
        chk_instret("post_rst_instret");

        drive(0, 0, 0, 7'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0);
        step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
